// File: rtl/motion_pkg.sv
// Shared types for the single-axis motion executor: phase and FSM state encodings
// plus the default motion tick divider.
package motion_pkg;

    localparam int unsigned TICK_DIV_DEFAULT = 50;

    typedef enum logic [1:0] {
        PH_ACCEL  = 2'd0,
        PH_CRUISE = 2'd1,
        PH_DECEL  = 2'd2,
        PH_TAIL   = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Motion tick divider: counts 0..TICK_DIV-1 and flags a tick at the terminal count.
// Holding clear keeps the count at zero so the first tick lands TICK_DIV cycles later.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = !clear_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear_i || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axis_motion_exec.sv
// Single-axis motion executor: plays a four-phase move out in real time using a
// velocity/position DDA whose position carry produces the step pulses.
module axis_motion_exec
    import motion_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [3:0][63:0] timing_i,
    input  logic [31:0]      v_start_i,
    input  logic [31:0]      accel_i,
    input  logic             dir_i,
    output logic             step_o,
    output logic             dir_out_o,
    output logic [1:0]       phase_o,
    output logic             busy_o,
    output logic             finish_o
);

    state_e           state_q, state_d;
    phase_e           phase_q, phase_d;
    logic [3:0][63:0] timing_q, timing_d;
    logic [31:0]      accel_q, accel_d;
    logic [31:0]      v_q, v_d;
    logic [31:0]      posAcc_q, posAcc_d;
    logic [63:0]      t_q, t_d;
    logic             dirOut_q, dirOut_d;
    logic             step_q, step_d;

    logic        tick;
    logic        presClear;
    logic [32:0] posSum;
    logic [32:0] vInc;
    logic [31:0] vSat;
    logic [31:0] vDec;
    logic [63:0] tNext;
    logic [1:0]  phAdv;
    logic [1:0]  startPh;

    assign presClear = (state_q != ST_RUN);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(presClear),
        .tick_o (tick)
    );

    assign posSum = {1'b0, posAcc_q} + {1'b0, v_q};
    assign vInc   = {1'b0, v_q} + {1'b0, accel_q};
    assign vSat   = vInc[32] ? 32'hFFFF_FFFF : vInc[31:0];
    assign vDec   = (accel_q > v_q) ? 32'd0 : (v_q - accel_q);
    assign tNext  = t_q + 64'd1;

    // Equal boundaries collapse several phases into a single tick.
    always_comb begin
        phAdv = phase_q;
        for (int i = 0; i < 3; i++) begin
            if (phAdv != 2'd3 && tNext == timing_q[phAdv]) begin
                phAdv = phAdv + 2'd1;
            end
        end
    end

    // First non-empty phase; the tail is the fallback because timing[3] > 0 in RUN.
    always_comb begin
        startPh = 2'd3;
        for (int p = 2; p >= 0; p--) begin
            if (timing_i[p] != 64'd0) begin
                startPh = 2'(p);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        timing_d = timing_q;
        accel_d  = accel_q;
        v_d      = v_q;
        posAcc_d = posAcc_q;
        t_d      = t_q;
        dirOut_d = dirOut_q;
        step_d   = 1'b0;

        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        timing_d = timing_i;
                        accel_d  = accel_i;
                        v_d      = v_start_i;
                        dirOut_d = dir_i;
                        t_d      = 64'd0;
                        posAcc_d = 32'd0;
                        phase_d  = phase_e'(startPh);
                        state_d  = (timing_i[3] == 64'd0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        posAcc_d = posSum[31:0];
                        step_d   = posSum[32];
                        case (phase_q)
                            PH_ACCEL: v_d = vSat;
                            PH_DECEL: v_d = vDec;
                            default:  v_d = v_q;
                        endcase
                        t_d = tNext;
                        if (tNext == timing_q[3]) begin
                            state_d = ST_DONE;
                        end else begin
                            phase_d = phase_e'(phAdv);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            phase_q  <= PH_ACCEL;
            timing_q <= '0;
            accel_q  <= '0;
            v_q      <= '0;
            posAcc_q <= '0;
            t_q      <= '0;
            dirOut_q <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            timing_q <= timing_d;
            accel_q  <= accel_d;
            v_q      <= v_d;
            posAcc_q <= posAcc_d;
            t_q      <= t_d;
            dirOut_q <= dirOut_d;
            step_q   <= step_d;
        end
    end

    assign step_o    = step_q;
    assign dir_out_o = dirOut_q;
    assign phase_o   = phase_q;
    assign busy_o    = (state_q == ST_RUN);
    assign finish_o  = (state_q == ST_DONE);

endmodule

// File: tb/tb_axis_motion_exec.sv
// Directed bench for axis_motion_exec at TICK_DIV = 1 with hand-computed step,
// phase and completion timing for each scenario.
module tb_axis_motion_exec;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [3:0][63:0] timing;
    logic [31:0]      vStart;
    logic [31:0]      accel;
    logic             dir;
    logic             step;
    logic             dirOut;
    logic [1:0]       phase;
    logic             busy;
    logic             finish;

    int total = 0;
    int bad   = 0;

    axis_motion_exec #(
        .TICK_DIV(1)
    ) dut (
        .clk_i    (clk),
        .reset_i  (reset),
        .start_i  (start),
        .abort_i  (abort),
        .timing_i (timing),
        .v_start_i(vStart),
        .accel_i  (accel),
        .dir_i    (dir),
        .step_o   (step),
        .dir_out_o(dirOut),
        .phase_o  (phase),
        .busy_o   (busy),
        .finish_o (finish)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle start; returns 1ns after the edge that sampled it.
    task automatic applyStimulus(input logic [63:0] t0, input logic [63:0] t1,
                                 input logic [63:0] t2, input logic [63:0] t3,
                                 input logic [31:0] vs, input logic [31:0] acc,
                                 input logic d);
        timing[0] = t0;
        timing[1] = t1;
        timing[2] = t2;
        timing[3] = t3;
        vStart    = vs;
        accel     = acc;
        dir       = d;
        start     = 1'b1;
        nextCycle();
        start     = 1'b0;
    endtask

    task automatic runToFinish(input int maxCycles, output int steps,
                               output int cyc, output bit timedOut);
        steps    = 0;
        cyc      = 0;
        timedOut = 1'b1;
        for (int i = 1; i <= maxCycles; i++) begin
            nextCycle();
            if (step) steps++;
            if (finish) begin
                cyc      = i;
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({step, dirOut, phase, busy, finish} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %b want 000000", {step, dirOut, phase, busy, finish});
        end
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        nextCycle();
    endtask

    task automatic test_cruise();
        int steps = 0;
        int finAt = 0;
        applyStimulus(64'd0, 64'd4, 64'd4, 64'd4, 32'h8000_0000, 32'd0, 1'b1);
        total++;
        if (busy !== 1'b1) begin bad++; $display("[TB] FAIL cruise_busy: got %b want 1", busy); end
        total++;
        if (dirOut !== 1'b1) begin bad++; $display("[TB] FAIL cruise_dir: got %b want 1", dirOut); end
        for (int k = 1; k <= 4; k++) begin
            total++;
            if (phase !== 2'd1) begin bad++; $display("[TB] FAIL cruise_phase tick %0d: got %0d want 1", k, phase); end
            nextCycle();
            if (step) steps++;
            if (finish && finAt == 0) finAt = k;
        end
        total++;
        if (steps != 2) begin bad++; $display("[TB] FAIL cruise_steps: got %0d want 2", steps); end
        total++;
        if (finAt != 4) begin bad++; $display("[TB] FAIL cruise_finish_time: got %0d want 4", finAt); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL cruise_busy_end: got %b want 0", busy); end
        nextCycle();
        total++;
        if ({finish, step} !== 2'b10) begin bad++; $display("[TB] FAIL cruise_hold: got finish,step=%b want 10", {finish, step}); end
    endtask

    task automatic test_accel_decel();
        logic [1:0] expPh [4] = '{2'd0, 2'd0, 2'd2, 2'd2};
        int steps = 0;
        logic stepWithFinish = 1'b0;
        applyStimulus(64'd2, 64'd2, 64'd4, 64'd4, 32'd0, 32'h4000_0000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (phase !== expPh[k]) begin bad++; $display("[TB] FAIL ad_phase tick %0d: got %0d want %0d", k + 1, phase, expPh[k]); end
            nextCycle();
            if (step) begin
                steps++;
                stepWithFinish = finish;
            end
        end
        total++;
        if (steps != 1) begin bad++; $display("[TB] FAIL ad_steps: got %0d want 1", steps); end
        total++;
        if (stepWithFinish !== 1'b1) begin bad++; $display("[TB] FAIL ad_step_with_finish: got %b want 1", stepWithFinish); end
    endtask

    task automatic test_saturation();
        int steps;
        int cyc;
        bit timedOut;
        int firstSteps;
        applyStimulus(64'd1, 64'd1, 64'd1, 64'd3, 32'hFFFF_FFF0, 32'h0000_0100, 1'b0);
        nextCycle();
        firstSteps = step ? 1 : 0;
        total++;
        if (dut.v_q !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL sat_v: got %h want ffffffff", dut.v_q); end
        total++;
        if (phase !== 2'd3) begin bad++; $display("[TB] FAIL sat_phase: got %0d want 3", phase); end
        runToFinish(10, steps, cyc, timedOut);
        total++;
        if (timedOut || cyc != 2) begin bad++; $display("[TB] FAIL sat_finish: got cycles=%0d timeout=%0d want 2", cyc, timedOut); end
        total++;
        if (firstSteps + steps != 2) begin bad++; $display("[TB] FAIL sat_steps: got %0d want 2", firstSteps + steps); end
    endtask

    task automatic test_decel_underflow();
        int steps;
        int cyc;
        bit timedOut;
        applyStimulus(64'd0, 64'd0, 64'd1, 64'd2, 32'h0000_0010, 32'h0000_0100, 1'b0);
        total++;
        if (phase !== 2'd2) begin bad++; $display("[TB] FAIL uf_start_phase: got %0d want 2", phase); end
        nextCycle();
        total++;
        if (dut.v_q !== 32'd0) begin bad++; $display("[TB] FAIL uf_v: got %h want 00000000", dut.v_q); end
        runToFinish(10, steps, cyc, timedOut);
        total++;
        if (timedOut || finish !== 1'b1) begin bad++; $display("[TB] FAIL uf_finish: got finish=%b timeout=%0d want 1", finish, timedOut); end
        total++;
        if (steps != 0) begin bad++; $display("[TB] FAIL uf_steps: got %0d want 0", steps); end
    endtask

    task automatic test_zero_move();
        logic busySeen;
        applyStimulus(64'd0, 64'd0, 64'd0, 64'd0, 32'h1234_5678, 32'd0, 1'b1);
        busySeen = busy;
        total++;
        if (finish !== 1'b1) begin bad++; $display("[TB] FAIL zero_finish: got %b want 1", finish); end
        repeat (3) begin
            nextCycle();
            busySeen = busySeen | busy;
        end
        total++;
        if (busySeen !== 1'b0) begin bad++; $display("[TB] FAIL zero_busy: got %b want 0", busySeen); end
    endtask

    task automatic test_back_to_back();
        int steps;
        int cyc;
        bit timedOut;
        applyStimulus(64'd0, 64'd4, 64'd4, 64'd4, 32'h8000_0000, 32'd0, 1'b0);
        nextCycle();
        start = 1'b1;
        nextCycle();
        start = 1'b0;
        total++;
        if (dut.t_q !== 64'd2) begin bad++; $display("[TB] FAIL btb_t: got %0d want 2", dut.t_q); end
        total++;
        if ({phase, step} !== 3'b011) begin bad++; $display("[TB] FAIL btb_phase_step: got %b want 011", {phase, step}); end
        runToFinish(10, steps, cyc, timedOut);
        total++;
        if (timedOut || cyc != 2 || steps != 1) begin
            bad++;
            $display("[TB] FAIL btb_finish: got cycles=%0d steps=%0d timeout=%0d want 2/1/0", cyc, steps, timedOut);
        end
    endtask

    task automatic test_abort();
        int steps = 0;
        logic finSeen = 1'b0;
        applyStimulus(64'd0, 64'd4, 64'd4, 64'd4, 32'h8000_0000, 32'd0, 1'b0);
        nextCycle();
        abort = 1'b1;
        nextCycle();
        abort = 1'b0;
        total++;
        if ({busy, finish, step} !== 3'b000) begin bad++; $display("[TB] FAIL abort_now: got %b want 000", {busy, finish, step}); end
        repeat (5) begin
            nextCycle();
            if (step) steps++;
            finSeen = finSeen | finish | busy;
        end
        total++;
        if (steps != 0 || finSeen !== 1'b0) begin bad++; $display("[TB] FAIL abort_after: got steps=%0d active=%b want 0/0", steps, finSeen); end
    endtask

    task automatic test_reset_mid_move();
        applyStimulus(64'd0, 64'd4, 64'd4, 64'd4, 32'h8000_0000, 32'd0, 1'b1);
        nextCycle();
        nextCycle();
        total++;
        if (step !== 1'b1) begin bad++; $display("[TB] FAIL rst_pre_step: got %b want 1", step); end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({step, dirOut, phase, busy, finish} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL rst_async: got %b want 000000", {step, dirOut, phase, busy, finish});
        end
        nextCycle();
        total++;
        if ({step, dirOut, phase, busy, finish} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL rst_hold: got %b want 000000", {step, dirOut, phase, busy, finish});
        end
        #2 reset = 1'b0;
        nextCycle();
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        dir    = 1'b0;
        timing = '0;
        vStart = 32'd0;
        accel  = 32'd0;
        $display("[TB] axis_motion_exec directed tests");
        test_reset();
        test_cruise();
        test_accel_decel();
        test_saturation();
        test_decel_underflow();
        test_zero_move();
        test_back_to_back();
        test_abort();
        test_reset_mid_move();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
